spi_cmd_decoder: RTL
====================

# spi_cmd_decoder

Packet-level command decoder sitting directly downstream of `simple_spi_slave` in the CLK_40 domain. Consumes the slave's received bytes and framing strobes, parses WRITE/READ/STATUS packets, and drives a single-port memory interface (frame/config RAM) with auto-incrementing addresses. For reads and status it supplies the slave's `tx_data`/`tx_data_strobe`.

## Interface
Parameters:
- `ADDR_W`, 16: memory address width. Address is taken from 2 header bytes and truncated to `ADDR_W` bits.
- `DATA_W`, 8: memory data width. Fixed at 8; any other value is a synthesis error.

Ports:
- `CLK_40` in 1: sole clock, 40 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from the SPI slave, valid when `rx_data_strobe` is high.
- `rx_data_strobe` in 1: 1-cycle pulse per received byte.
- `rx_start` in 1: 1-cycle pulse at CS assertion (packet start).
- `rx_end_strobe` in 1: 1-cycle pulse at CS deassertion (packet end).
- `tx_data` out 8: next byte for the slave to shift out.
- `tx_data_strobe` out 1: 1-cycle pulse loading `tx_data` into the slave.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: write enable, 1-cycle pulse.
- `mem_re` out 1: read enable, 1-cycle pulse.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_re`.
- `busy` out 1: high whenever the state is not IDLE.
- `pkt_done` out 1: 1-cycle pulse when a well-formed packet ends.
- `err_count` out 8: count of malformed packets; saturates at 0xFF.

## Operation
- Packet: byte0 = command, byte1 = addr[15:8], byte2 = addr[7:0], then payload.
- Commands:
  - 0x01 WRITE: each payload byte causes `mem_we` with `mem_wdata`=byte at the current address. The address then increments.
  - 0x02 READ: after byte2, a read is issued at the current address. The returned data goes to `tx_data` with `tx_data_strobe`, and the address increments. Each later received (dummy) byte triggers the next prefetch the same way.
  - 0x03 STATUS: no address bytes. On the command byte, `tx_data`={err_count} and `tx_data_strobe` pulses. Following bytes are ignored.
  - Any other command: DISCARD state; counts as an error at packet end.
- States and transitions:
  - IDLE to CMD on `rx_start`.
  - CMD to ADDR_H (WRITE/READ), STATUS, or DISCARD, by command byte.
  - ADDR_H to ADDR_L.
  - ADDR_L to WRITE, or to READ.
  - WRITE, READ, STATUS and DISCARD hold until `rx_end_strobe`.
- `rx_start` in any state restarts at CMD. The address register and the pending read are cleared. If the interrupted packet never reached a payload state, it counts as an error.
- `rx_end_strobe` in any state returns to IDLE:
  - in CMD/ADDR_H/ADDR_L (short packet) or DISCARD: increment `err_count`, saturating;
  - in WRITE, READ or STATUS: pulse `pkt_done`, even if zero payload bytes were received;
  - in IDLE: no effect.
- Bytes received while in IDLE are ignored.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000.

## Timing
- Reset values: `tx_data`=0x00 and `mem_addr`=0. `mem_wdata`, `err_count`, every strobe and `busy` are all 0. State is IDLE.
- WRITE: `mem_we`/`mem_addr`/`mem_wdata` are registered, one cycle after `rx_data_strobe`. The address increments in the same cycle as `mem_we`.
- READ:
  - `mem_re` is asserted the cycle after the strobe of byte2 or a dummy byte.
  - `mem_rdata` is captured the next cycle.
  - `tx_data_strobe` pulses the cycle after capture, 3 cycles after the triggering rx strobe.
  - SPI byte time (≥8 sck periods) exceeds 3 CLK_40 cycles. Back-to-back strobes closer than 3 cycles are unsupported.
- STATUS: `tx_data_strobe` pulses 1 cycle after the command byte's strobe.
- `rx_data_strobe` and `rx_end_strobe` in the same cycle: the byte is processed first (a write completes, or a read is issued and finishes its pipeline), then the state goes to IDLE. Error and `pkt_done` evaluation uses the post-byte state.
- `rx_start` and `rx_data_strobe` in the same cycle: the start wins and the byte is dropped.
- `pkt_done` and the `err_count` update occur 1 cycle after `rx_end_strobe`.
- Asynchronous reset mid-packet aborts immediately. Any in-flight `mem_re` result is discarded.

## Structure
- Shared package `nx4_spi_pkg`:
  - command constants `CMD_WRITE`=8'h01, `CMD_READ`=8'h02, `CMD_STATUS`=8'h03;
  - state encoding;
  - header length constant.
- Single module. The read pipeline (re, capture, tx strobe) is a natural sub-module, `spi_read_prefetch`, holding a 2-stage valid shift and a data register.

## Test plan
- WRITE 0x01,0x12,0x34,0xAA,0xBB, then end: `mem_we`@0x1234=0xAA, then `mem_we`@0x1235=0xBB, then `pkt_done`; `err_count`=0.
- READ 0x02,0x00,0x10 plus 2 dummies, with RAM[0x10]=0x5A and RAM[0x11]=0xC3: `tx_data` 0x5A, then 0xC3, each with `tx_data_strobe` 3 cycles after its trigger strobe.
- WRITE at 0xFFFF with 2 data bytes: writes land at 0xFFFF, then 0x0000.
- Short packet 0x01,0x12, then end; next, command 0x7E: `err_count` goes 1, then 2, with no `mem_we`. After 300 short packets `err_count` holds at 0xFF.
- STATUS 0x03 with `err_count`=2: `tx_data`=0x02 and `tx_data_strobe` 1 cycle after the command strobe.
- `rx_start` mid-WRITE payload, then `reset_n` low during a READ prefetch: the packet restarts at CMD with no error. On reset, all outputs go to their reset values with no trailing `tx_data_strobe`.

Source files
------------

// File: rtl/nx4_spi_pkg.sv
// Shared definitions for the SPI packet command decoder: command codes, header length and the
// parser state encoding.
package nx4_spi_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;

  // Command byte plus two address bytes.
  localparam int unsigned HDR_LEN = 3;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddrH,
    StAddrL,
    StWrite,
    StRead,
    StStatus,
    StDiscard
  } state_e;

  // A packet ending (or being interrupted) in one of these states is malformed.
  function automatic logic is_malformed(state_e s);
    return s inside {StCmd, StAddrH, StAddrL, StDiscard};
  endfunction

  function automatic logic is_payload(state_e s);
    return s inside {StWrite, StRead, StStatus};
  endfunction

endpackage

// File: rtl/spi_read_prefetch.sv
// Read pipeline: mem_re, one cycle later capture of mem_rdata, one cycle later tx strobe.
// The same output register also carries the STATUS byte.
module spi_read_prefetch (
  input  logic       CLK_40,
  input  logic       reset_n,
  input  logic       issue,
  input  logic       flush,
  input  logic       status_load,
  input  logic [7:0] status_byte,
  input  logic [7:0] mem_rdata,
  output logic       mem_re,
  output logic [7:0] tx_data,
  output logic       tx_data_strobe
);

  // valid_q[0]: mem_re cycle, valid_q[1]: mem_rdata valid cycle.
  logic [1:0] valid_q;
  logic [7:0] data_q;
  logic       stb_q;

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 2'b00;
      data_q  <= 8'h00;
      stb_q   <= 1'b0;
    end else begin
      valid_q <= flush ? 2'b00 : {valid_q[0], issue};
      stb_q   <= 1'b0;
      if (valid_q[1] && !flush) begin
        data_q <= mem_rdata;
        stb_q  <= 1'b1;
      end else if (status_load) begin
        data_q <= status_byte;
        stb_q  <= 1'b1;
      end
    end
  end

  assign mem_re         = valid_q[0];
  assign tx_data        = data_q;
  assign tx_data_strobe = stb_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Packet-level WRITE/READ/STATUS decoder behind the SPI slave, driving a single-port memory with
// auto-incrementing addresses.
module spi_cmd_decoder
  import nx4_spi_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK_40,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_strobe,
  input  logic              rx_start,
  input  logic              rx_end_strobe,
  output logic [7:0]        tx_data,
  output logic              tx_data_strobe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              pkt_done,
  output logic [7:0]        err_count
);

  if (DATA_W != 8) begin : g_data_w_check
    $error("spi_cmd_decoder: DATA_W must be 8");
  end
  if (ADDR_W > 16 || ADDR_W == 0) begin : g_addr_w_check
    $error("spi_cmd_decoder: ADDR_W must be 1..16");
  end

  state_e            state_q, state_d;
  logic              is_read_q, is_read_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              pkt_done_q, pkt_done_d;
  logic [7:0]        err_q;
  logic              err_inc;
  logic              issue, flush, status_load;
  logic [15:0]       hdr_addr;
  logic [ADDR_W-1:0] addr_cur;

  assign hdr_addr = {addr_hi_q, rx_data};
  // The first read uses the address arriving with byte2; later reads use the running pointer.
  assign addr_cur = (state_q == StAddrL) ? hdr_addr[ADDR_W-1:0] : addr_q;

  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    pkt_done_d  = 1'b0;
    err_inc     = 1'b0;
    issue       = 1'b0;
    flush       = 1'b0;
    status_load = 1'b0;

    if (rx_start) begin
      state_d   = StCmd;
      addr_hi_d = 8'h00;
      addr_d    = '0;
      flush     = 1'b1;
      err_inc   = is_malformed(state_q);
    end else begin
      if (rx_data_strobe) begin
        unique case (state_q)
          StCmd: begin
            unique case (rx_data)
              CMD_WRITE: begin
                is_read_d = 1'b0;
                state_d   = StAddrH;
              end
              CMD_READ: begin
                is_read_d = 1'b1;
                state_d   = StAddrH;
              end
              CMD_STATUS: begin
                state_d     = StStatus;
                status_load = 1'b1;
              end
              default: state_d = StDiscard;
            endcase
          end
          StAddrH: begin
            addr_hi_d = rx_data;
            state_d   = StAddrL;
          end
          StAddrL: begin
            if (is_read_q) begin
              state_d = StRead;
              issue   = 1'b1;
            end else begin
              state_d = StWrite;
              addr_d  = hdr_addr[ADDR_W-1:0];
            end
          end
          StWrite: begin
            mem_we_d    = 1'b1;
            mem_wdata_d = rx_data;
            mem_addr_d  = addr_q;
            addr_d      = addr_q + ADDR_W'(1);
          end
          StRead:  issue = 1'b1;
          default: ;
        endcase
      end

      if (issue) begin
        mem_addr_d = addr_cur;
        addr_d     = addr_cur + ADDR_W'(1);
      end

      // End is judged on the state reached after any coincident byte.
      if (rx_end_strobe) begin
        err_inc    = is_malformed(state_d);
        pkt_done_d = is_payload(state_d);
        state_d    = StIdle;
      end
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      is_read_q   <= 1'b0;
      addr_hi_q   <= 8'h00;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      pkt_done_q  <= 1'b0;
      err_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      pkt_done_q  <= pkt_done_d;
      if (err_inc && err_q != 8'hFF) begin
        err_q <= err_q + 8'h01;
      end
    end
  end

  spi_read_prefetch u_read_prefetch (
    .CLK_40         (CLK_40),
    .reset_n        (reset_n),
    .issue          (issue),
    .flush          (flush),
    .status_load    (status_load),
    .status_byte    (err_q),
    .mem_rdata      (mem_rdata),
    .mem_re         (mem_re),
    .tx_data        (tx_data),
    .tx_data_strobe (tx_data_strobe)
  );

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != StIdle);
  assign pkt_done  = pkt_done_q;
  assign err_count = err_q;

endmodule
